audio_tone_gen: RTL



---
 rtl/audio_tone_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/audio_tone_gen.sv
// Stereo test-tone generator: phase accumulators -> waveform shaper -> volume scaler.
// Define AUDIO_TONE_GEN_DITHER_EN for LFSR-based random rounding in the scaler.
module audio_tone_gen #(
  parameter int AUDIO_WIDTH = 16,
  parameter int PHASE_WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       phase_sync,
  input  logic [PHASE_WIDTH-1:0]     freq_l,
  input  logic [PHASE_WIDTH-1:0]     freq_r,
  input  logic [1:0]                 wave_l,
  input  logic [1:0]                 wave_r,
  input  logic [7:0]                 volume,
  output logic [2*AUDIO_WIDTH-1:0]   sample_data,
  output logic                       sample_en,
  input  logic                       sample_full
);

  localparam int AW    = AUDIO_WIDTH;
  localparam int PW    = PHASE_WIDTH;
  localparam int PRODW = AW + 9;

  function automatic logic signed [AW-1:0] shape(input logic [AW-1:0] p,
                                                 input logic [1:0]    wv);
    logic [AW-1:0]        t;
    logic signed [AW-1:0] r;
    t = '0;
    r = '0;
    case (wv)
      2'd0: r = {~p[AW-1], p[AW-2:0]};
      2'd1: r = p[AW-1] ? {1'b1, {(AW-2){1'b0}}, 1'b1} : {1'b0, {(AW-1){1'b1}}};
      2'd2: begin
        t = p[AW-1] ? ~{p[AW-2:0], 1'b0} : {p[AW-2:0], 1'b0};
        r = {~t[AW-1], t[AW-2:0]};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Gain of vol/256 with an additive rounding offset d, floor via arithmetic shift.
  function automatic logic signed [AW-1:0] scale(input logic signed [AW-1:0] w,
                                                 input logic [7:0]           vol,
                                                 input logic [7:0]           d);
    logic signed [PRODW-1:0] prod;
    logic signed [PRODW-1:0] sum;
    prod = PRODW'(w) * PRODW'($signed({1'b0, vol}));
    sum  = prod + $signed({{(AW+1){1'b0}}, d});
    return AW'(sum >>> 8);
  endfunction

  logic                 advance;
  logic [PW-1:0]        phase_l_q, phase_l_d, phase_r_q, phase_r_d;
  logic                 vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [AW-1:0]        ph_l_p0_q, ph_l_p0_d, ph_r_p0_q, ph_r_p0_d;
  logic [1:0]           wv_l_p0_q, wv_l_p0_d, wv_r_p0_q, wv_r_p0_d;
  logic signed [AW-1:0] shp_l_p1_q, shp_l_p1_d, shp_r_p1_q, shp_r_p1_d;
  logic signed [AW-1:0] out_l_p2_q, out_l_p2_d, out_r_p2_q, out_r_p2_d;
  logic [7:0]           dither;

  assign advance     = ~vld_p2_q | ~sample_full;
  assign sample_en   = vld_p2_q & ~sample_full & ~reset;
  assign sample_data = {out_l_p2_q, out_r_p2_q};

`ifdef AUDIO_TONE_GEN_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // The offset for a newly loaded sample already reflects this cycle's consumption.
  always_comb begin
    lfsr_d = lfsr_q;
    if (sample_en) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    dither = lfsr_d[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign dither = '0;
`endif

  always_comb begin
    phase_l_d  = phase_l_q;
    phase_r_d  = phase_r_q;
    vld_p0_d   = vld_p0_q;
    vld_p1_d   = vld_p1_q;
    vld_p2_d   = vld_p2_q;
    ph_l_p0_d  = ph_l_p0_q;
    ph_r_p0_d  = ph_r_p0_q;
    wv_l_p0_d  = wv_l_p0_q;
    wv_r_p0_d  = wv_r_p0_q;
    shp_l_p1_d = shp_l_p1_q;
    shp_r_p1_d = shp_r_p1_q;
    out_l_p2_d = out_l_p2_q;
    out_r_p2_d = out_r_p2_q;
    if (advance) begin
      // S1: phase capture and accumulate
      vld_p0_d = run;
      if (run) begin
        ph_l_p0_d = phase_l_q[PW-1 -: AW];
        ph_r_p0_d = phase_r_q[PW-1 -: AW];
        wv_l_p0_d = wave_l;
        wv_r_p0_d = wave_r;
        phase_l_d = phase_l_q + freq_l;
        phase_r_d = phase_r_q + freq_r;
      end
      // S2: waveform shaping
      vld_p1_d   = vld_p0_q;
      shp_l_p1_d = shape(ph_l_p0_q, wv_l_p0_q);
      shp_r_p1_d = shape(ph_r_p0_q, wv_r_p0_q);
      // S3: volume scaling into the output register
      vld_p2_d   = vld_p1_q;
      out_l_p2_d = scale(shp_l_p1_q, volume, dither);
      out_r_p2_d = scale(shp_r_p1_q, volume, dither);
    end
    if (phase_sync) begin
      phase_l_d = '0;
      phase_r_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_l_q  <= '0;
      phase_r_q  <= '0;
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      out_l_p2_q <= '0;
      out_r_p2_q <= '0;
    end else begin
      phase_l_q  <= phase_l_d;
      phase_r_q  <= phase_r_d;
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      out_l_p2_q <= out_l_p2_d;
      out_r_p2_q <= out_r_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    ph_l_p0_q  <= ph_l_p0_d;
    ph_r_p0_q  <= ph_r_p0_d;
    wv_l_p0_q  <= wv_l_p0_d;
    wv_r_p0_q  <= wv_r_p0_d;
    shp_l_p1_q <= shp_l_p1_d;
    shp_r_p1_q <= shp_r_p1_d;
  end

endmodule
